// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_sched
//  Purpose  : Round-robin scheduler that shares a single uart_tx transmitter
//             among NUM_REQ byte requesters. A winning requester's byte and
//             the current line configuration are captured together, the
//             transmitter is started with a one-cycle pulse, and the captured
//             values are held stable until the transmitter reports the end of
//             the frame (or a timeout aborts it). A short idle gap follows
//             every frame before the next arbitration.
//
//  Parameters
//    NUM_REQ        : number of requesters (2..8)
//    TIMEOUT_CYCLES : cycles from start pulse to finish pulse before abort (>=2)
//    GAP_CYCLES     : idle cycles after each frame before re-arbitration (>=1)
//
//  Ports
//    i_sys_clk      : system clock, single clock domain
//    i_sys_rst_n    : asynchronous active-low reset
//    i_en           : 1 = new grants allowed; a frame in flight always completes
//    i_req          : per-requester request, held with its byte until o_ack
//    i_req_data     : requester k byte on [8k+7:8k]
//    i_cfg_bps      : baud select, passed to the transmitter at capture
//    i_cfg_clk      : clock-frequency select, passed to the transmitter at capture
//    o_ack          : one-cycle pulse, byte of requester k captured
//    o_done         : one-cycle pulse, frame of requester k fully sent
//    o_err          : one-cycle pulse, frame aborted on timeout
//    o_busy         : high in every state except IDLE
//    o_grant_id     : index of the current / last granted requester
//    o_tx_data      : byte to the transmitter
//    o_tx_flag      : one-cycle start pulse to the transmitter
//    o_tx_uart_bps  : baud select to the transmitter
//    o_tx_uart_clk  : clock-frequency select to the transmitter
//    i_tx_finish    : end-of-frame pulse from the transmitter
//
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_sched #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int GAP_CYCLES     = 2
) (
    input  logic                       i_sys_clk,
    input  logic                       i_sys_rst_n,
    input  logic                       i_en,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [8*NUM_REQ-1:0]       i_req_data,
    input  logic [2:0]                 i_cfg_bps,
    input  logic                       i_cfg_clk,
    output logic [NUM_REQ-1:0]         o_ack,
    output logic [NUM_REQ-1:0]         o_done,
    output logic                       o_err,
    output logic                       o_busy,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
    output logic [7:0]                 o_tx_data,
    output logic                       o_tx_flag,
    output logic [2:0]                 o_tx_uart_bps,
    output logic                       o_tx_uart_clk,
    input  logic                       i_tx_finish
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int C_ID_W  = $clog2(NUM_REQ);
    localparam int C_TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int C_GAP_W = $clog2(GAP_CYCLES + 1);

    // Timer value on the last BUSY cycle before the frame is declared lost.
    localparam logic [C_TMR_W-1:0] C_TMR_LAST = C_TMR_W'(TIMEOUT_CYCLES - 1);
    // Gap counter value on the last idle cycle before returning to IDLE.
    localparam logic [C_GAP_W-1:0] C_GAP_LAST = C_GAP_W'(GAP_CYCLES - 1);

    localparam logic [NUM_REQ-1:0] C_ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [C_ID_W-1:0]  C_LAST_RST = C_ID_W'(NUM_REQ - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_BUSY   = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t               state_q,   state_d;
    logic [NUM_REQ-1:0]   ack_q,     ack_d;
    logic [NUM_REQ-1:0]   done_q,    done_d;
    logic                 err_q,     err_d;
    logic                 busy_q,    busy_d;
    logic                 flag_q,    flag_d;
    logic [C_ID_W-1:0]    grant_q,   grant_d;
    logic [C_ID_W-1:0]    last_q,    last_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [2:0]           bps_q,     bps_d;
    logic                 uclk_q,    uclk_d;
    logic [C_TMR_W-1:0]   timer_q,   timer_d;
    logic [C_GAP_W-1:0]   gap_q,     gap_d;

    // ------------------------------------------------------------------------
    // Requester byte lanes
    // ------------------------------------------------------------------------
    logic [7:0] w_bytes [NUM_REQ];

    genvar k;
    generate
        for (k = 0; k < NUM_REQ; k++) begin : g_lane
            assign w_bytes[k] = i_req_data[8*k +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Round-robin winner search
    // ------------------------------------------------------------------------
    // Index "offset" places after "base", wrapping modulo NUM_REQ. Offsets
    // never exceed NUM_REQ, so one conditional subtraction is enough.
    function automatic logic [C_ID_W-1:0] rr_idx(input logic [C_ID_W-1:0] base,
                                                 input int                off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return C_ID_W'(sum);
    endfunction

    logic              w_found;
    logic [C_ID_W-1:0] w_winner;

    // Search starts one past the last winner so the last winner is examined
    // last; this gives every active requester a turn before any repeats.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!w_found && i_req[rr_idx(last_q, i)]) begin
                w_found  = 1'b1;
                w_winner = rr_idx(last_q, i);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ack_d     = '0;
        done_d    = '0;
        err_d     = 1'b0;
        flag_d    = 1'b0;
        busy_d    = busy_q;
        grant_d   = grant_q;
        last_d    = last_q;
        tx_data_d = tx_data_q;
        bps_d     = bps_q;
        uclk_d    = uclk_q;
        timer_d   = timer_q;
        gap_d     = gap_q;

        case (state_q)
            S_IDLE: begin
                // Byte and line config are captured on the same edge so a
                // frame always goes out with the config seen at grant time.
                if (i_en && w_found) begin
                    tx_data_d = w_bytes[w_winner];
                    bps_d     = i_cfg_bps;
                    uclk_d    = i_cfg_clk;
                    grant_d   = w_winner;
                    last_d    = w_winner;
                    ack_d     = C_ONE_HOT0 << w_winner;
                    busy_d    = 1'b1;
                    state_d   = S_LAUNCH;
                end
            end

            S_LAUNCH: begin
                flag_d  = 1'b1;
                timer_d = '0;
                state_d = S_BUSY;
            end

            S_BUSY: begin
                // A finish arriving on the timeout cycle still counts as a
                // good frame, so it is tested first.
                if (i_tx_finish) begin
                    done_d  = C_ONE_HOT0 << grant_q;
                    gap_d   = '0;
                    state_d = S_GAP;
                end else if (timer_q == C_TMR_LAST) begin
                    err_d   = 1'b1;
                    gap_d   = '0;
                    state_d = S_GAP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_GAP: begin
                if (gap_q == C_GAP_LAST) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_q   <= S_IDLE;
            ack_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            flag_q    <= 1'b0;
            grant_q   <= '0;
            last_q    <= C_LAST_RST;
            tx_data_q <= 8'h00;
            bps_q     <= 3'd2;
            uclk_q    <= 1'b1;
            timer_q   <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            flag_q    <= flag_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            tx_data_q <= tx_data_d;
            bps_q     <= bps_d;
            uclk_q    <= uclk_d;
            timer_q   <= timer_d;
            gap_q     <= gap_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all straight from flops)
    // ------------------------------------------------------------------------
    assign o_ack         = ack_q;
    assign o_done        = done_q;
    assign o_err         = err_q;
    assign o_busy        = busy_q;
    assign o_grant_id    = grant_q;
    assign o_tx_data     = tx_data_q;
    assign o_tx_flag     = flag_q;
    assign o_tx_uart_bps = bps_q;
    assign o_tx_uart_clk = uclk_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_sched
//  Purpose  : Self-checking bench for uart_tx_sched (NUM_REQ=4,
//             TIMEOUT_CYCLES=100, GAP_CYCLES=2) with a behavioural
//             transmitter that answers each start pulse with a finish pulse
//             after a random delay.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_sched;

    localparam int C_NUM_REQ = 4;
    localparam int C_TIMEOUT = 100;
    localparam int C_GAP     = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_en;
    logic [3:0]  i_req;
    logic [31:0] i_req_data;
    logic [2:0]  i_cfg_bps;
    logic        i_cfg_clk;
    logic        i_tx_finish;
    logic [3:0]  o_ack;
    logic [3:0]  o_done;
    logic        o_err;
    logic        o_busy;
    logic [1:0]  o_grant_id;
    logic [7:0]  o_tx_data;
    logic        o_tx_flag;
    logic [2:0]  o_tx_uart_bps;
    logic        o_tx_uart_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int rr_last;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_sched #(
        .NUM_REQ        (C_NUM_REQ),
        .TIMEOUT_CYCLES (C_TIMEOUT),
        .GAP_CYCLES     (C_GAP)
    ) dut (
        .i_sys_clk     (clk),
        .i_sys_rst_n   (rst_n),
        .i_en          (i_en),
        .i_req         (i_req),
        .i_req_data    (i_req_data),
        .i_cfg_bps     (i_cfg_bps),
        .i_cfg_clk     (i_cfg_clk),
        .o_ack         (o_ack),
        .o_done        (o_done),
        .o_err         (o_err),
        .o_busy        (o_busy),
        .o_grant_id    (o_grant_id),
        .o_tx_data     (o_tx_data),
        .o_tx_flag     (o_tx_flag),
        .o_tx_uart_bps (o_tx_uart_bps),
        .o_tx_uart_clk (o_tx_uart_clk),
        .i_tx_finish   (i_tx_finish)
    );

    // ------------------------------------------------------------------------
    // Behavioural transmitter: latches the line values on the start pulse,
    // demands they stay put, and finishes after a random number of cycles.
    // ------------------------------------------------------------------------
    bit         tx_auto = 1'b1;
    bit         m_active = 1'b0;
    logic [7:0] m_data;
    logic [2:0] m_bps;
    logic       m_clk;
    int         m_cnt = 0;
    int         fin_cyc = -1;

    always begin
        @(posedge clk);
        #1;
        if (!tx_auto) begin
            m_active = 1'b0;
            m_cnt    = 0;
        end else begin
            i_tx_finish = 1'b0;
            if (m_active) begin
                n_cmp++;
                if (o_tx_data !== m_data || o_tx_uart_bps !== m_bps || o_tx_uart_clk !== m_clk) begin
                    n_bad++;
                    $display("FAIL line_stable: data=%h bps=%0d clk=%b, want data=%h bps=%0d clk=%b",
                             o_tx_data, o_tx_uart_bps, o_tx_uart_clk, m_data, m_bps, m_clk);
                end
            end
            if (o_tx_flag === 1'b1 && !m_active) begin
                m_active = 1'b1;
                m_data   = o_tx_data;
                m_bps    = o_tx_uart_bps;
                m_clk    = o_tx_uart_clk;
                m_cnt    = int'($urandom_range(2, 20));
            end else if (m_active) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    i_tx_finish = 1'b1;
                    m_active    = 1'b0;
                    fin_cyc     = cyc;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, n_bad=%0d", n_bad);
        $fatal(1);
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin reference: first requester after "last", wrapping around.
    function automatic int rr_pick(input int last, input logic [3:0] req);
        for (int i = 1; i <= C_NUM_REQ; i++) begin
            if (req[(last + i) % C_NUM_REQ]) return (last + i) % C_NUM_REQ;
        end
        return -1;
    endfunction

    // Waits for a pulse on ack (kind 0), done (kind 1) or err (kind 2).
    // idx is the set bit for a one-hot pulse, -1 otherwise.
    task automatic wait_evt(input int kind, input int budget,
                            output int idx, output int at, output bit ok);
        logic [3:0] v;
        ok  = 1'b0;
        idx = -1;
        at  = -1;
        for (int n = 0; n < budget && !ok; n++) begin
            tick();
            case (kind)
                0:       v = o_ack;
                1:       v = o_done;
                default: v = {3'b000, o_err};
            endcase
            if (v != 4'b0000) begin
                ok = 1'b1;
                at = cyc;
                for (int b = 0; b < 4; b++) begin
                    if (v == (4'b0001 << b)) idx = b;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n   = 1'b1;
        rr_last = C_NUM_REQ - 1;
        tick();
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (o_ack !== 4'b0 || o_done !== 4'b0 || o_err !== 1'b0 || o_busy !== 1'b0 || o_tx_flag !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_pulses: ack=%b done=%b err=%b busy=%b flag=%b, want all 0",
                     o_ack, o_done, o_err, o_busy, o_tx_flag);
        end
        n_cmp++;
        if (o_tx_data !== 8'h00 || o_grant_id !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_data: data=%h grant=%0d, want 00 / 0", o_tx_data, o_grant_id);
        end
        n_cmp++;
        if (o_tx_uart_bps !== 3'd2 || o_tx_uart_clk !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_cfg: bps=%0d clk=%b, want 2 / 1", o_tx_uart_bps, o_tx_uart_clk);
        end
        rst_n   = 1'b1;
        rr_last = C_NUM_REQ - 1;
        tick();
    endtask

    task automatic test_single();
        int idx, at, t0;
        bit ok;
        i_cfg_bps        = 3'd6;
        i_cfg_clk        = 1'b1;
        i_req_data[7:0]  = 8'hA5;
        i_req            = 4'b0001;
        t0               = cyc;
        wait_evt(0, 10, idx, at, ok);
        n_cmp++;
        if (!ok || idx != 0 || at != t0 + 1) begin
            n_bad++;
            $display("FAIL single_ack: ok=%0d idx=%0d at=%0d, want idx=0 at=%0d", ok, idx, at, t0 + 1);
        end
        i_req = 4'b0000;
        n_cmp++;
        if (o_tx_data !== 8'hA5 || o_tx_uart_bps !== 3'd6 || o_tx_uart_clk !== 1'b1 || o_grant_id !== 2'd0) begin
            n_bad++;
            $display("FAIL single_capture: data=%h bps=%0d clk=%b grant=%0d, want A5/6/1/0",
                     o_tx_data, o_tx_uart_bps, o_tx_uart_clk, o_grant_id);
        end
        tick();
        n_cmp++;
        if (o_ack !== 4'b0 || o_tx_flag !== 1'b1 || o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL single_flag: ack=%b flag=%b busy=%b, want 0000/1/1", o_ack, o_tx_flag, o_busy);
        end
        tick();
        n_cmp++;
        if (o_tx_flag !== 1'b0) begin
            n_bad++;
            $display("FAIL single_flag_width: flag=%b, want 0", o_tx_flag);
        end
        wait_evt(1, 200, idx, at, ok);
        n_cmp++;
        if (!ok || idx != 0 || at != fin_cyc + 1) begin
            n_bad++;
            $display("FAIL single_done: ok=%0d idx=%0d at=%0d, want idx=0 at=%0d", ok, idx, at, fin_cyc + 1);
        end
        rr_last = 0;
    endtask

    task automatic test_rr_all();
        int exp_seq [8] = '{0, 1, 2, 3, 0, 2, 0, 2};
        int idx, at, prev_done;
        bit ok;
        do_reset();
        i_req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        i_req      = 4'b1111;
        prev_done  = -1;
        for (int j = 0; j < 8; j++) begin
            if (j == 4) i_req = 4'b0101;
            wait_evt(0, 20, idx, at, ok);
            n_cmp++;
            if (!ok || idx != exp_seq[j] || o_tx_data !== 8'(8'h10 + exp_seq[j]) ||
                (prev_done >= 0 && at != prev_done + C_GAP + 1)) begin
                n_bad++;
                $display("FAIL rr_grant%0d: idx=%0d data=%h at=%0d, want idx=%0d data=%h at=%0d",
                         j, idx, o_tx_data, at, exp_seq[j], 8'(8'h10 + exp_seq[j]), prev_done + C_GAP + 1);
            end
            wait_evt(1, 200, idx, at, ok);
            n_cmp++;
            if (!ok || idx != exp_seq[j]) begin
                n_bad++;
                $display("FAIL rr_done%0d: ok=%0d idx=%0d, want %0d", j, ok, idx, exp_seq[j]);
            end
            prev_done = at;
        end
        rr_last = 2;
        i_req   = 4'b0000;
    endtask

    task automatic test_random();
        int idx, at, prev_done, exp;
        bit ok;
        logic [7:0] exp_byte;
        logic [2:0] exp_bps;
        logic       exp_clk;
        prev_done = -1;
        for (int j = 0; j < 20; j++) begin
            i_req      = 4'($urandom_range(1, 15));
            i_req_data = $urandom;
            i_cfg_bps  = 3'($urandom_range(0, 7));
            i_cfg_clk  = 1'($urandom_range(0, 1));
            exp        = rr_pick(rr_last, i_req);
            exp_byte   = 8'(i_req_data >> (8 * exp));
            exp_bps    = i_cfg_bps;
            exp_clk    = i_cfg_clk;
            wait_evt(0, 20, idx, at, ok);
            n_cmp++;
            if (!ok || idx != exp || o_grant_id !== 2'(exp) || o_tx_data !== exp_byte ||
                o_tx_uart_bps !== exp_bps || o_tx_uart_clk !== exp_clk ||
                (prev_done >= 0 && at != prev_done + C_GAP + 1)) begin
                n_bad++;
                $display("FAIL rand%0d_grant: idx=%0d gid=%0d data=%h bps=%0d clk=%b at=%0d, want %0d/%h/%0d/%b at=%0d",
                         j, idx, o_grant_id, o_tx_data, o_tx_uart_bps, o_tx_uart_clk, at,
                         exp, exp_byte, exp_bps, exp_clk, prev_done + C_GAP + 1);
            end
            rr_last = exp;
            wait_evt(1, 200, idx, at, ok);
            n_cmp++;
            if (!ok || idx != exp) begin
                n_bad++;
                $display("FAIL rand%0d_done: ok=%0d idx=%0d, want %0d", j, ok, idx, exp);
            end
            prev_done = at;
        end
        i_req = 4'b0000;
        for (int n = 0; n < C_GAP + 2; n++) tick();
    endtask

    task automatic test_timeout();
        int idx, at, flag_cyc, err_cyc;
        bit ok, saw_done, saw_err;
        tx_auto     = 1'b0;
        i_tx_finish = 1'b0;
        i_req_data[15:8] = 8'h3C;
        i_req       = 4'b0010;
        wait_evt(0, 20, idx, at, ok);
        n_cmp++;
        if (!ok || idx != 1 || o_tx_data !== 8'h3C) begin
            n_bad++;
            $display("FAIL timeout_ack: ok=%0d idx=%0d data=%h, want 1 / 3C", ok, idx, o_tx_data);
        end
        rr_last = 1;
        i_req   = 4'b0000;
        tick();
        flag_cyc = cyc;
        saw_done = 1'b0;
        saw_err  = 1'b0;
        err_cyc  = -1;
        for (int n = 0; n < 150 && !saw_err; n++) begin
            tick();
            if (o_done !== 4'b0) saw_done = 1'b1;
            if (o_err === 1'b1) begin
                saw_err = 1'b1;
                err_cyc = cyc;
            end
        end
        n_cmp++;
        if (!saw_err || saw_done || err_cyc - flag_cyc != C_TIMEOUT || o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_err: err=%0d done=%0d delay=%0d busy=%b, want 1/0/%0d/1",
                     saw_err, saw_done, err_cyc - flag_cyc, o_busy, C_TIMEOUT);
        end
        tick();
        n_cmp++;
        if (o_err !== 1'b0 || o_busy !== 1'b1 || o_done !== 4'b0) begin
            n_bad++;
            $display("FAIL timeout_gap: err=%b busy=%b done=%b, want 0/1/0000", o_err, o_busy, o_done);
        end
        for (int n = 0; n < C_GAP; n++) tick();
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_idle: busy=%b, want 0", o_busy);
        end
        tx_auto = 1'b1;
    endtask

    task automatic test_cfg_hold();
        int idx, at;
        bit ok, bad, seen;
        i_cfg_bps         = 3'd6;
        i_cfg_clk         = 1'b1;
        i_req_data[23:16] = 8'h5A;
        i_req             = 4'b0100;
        wait_evt(0, 20, idx, at, ok);
        n_cmp++;
        if (!ok || idx != 2 || o_tx_uart_bps !== 3'd6) begin
            n_bad++;
            $display("FAIL cfg_ack: ok=%0d idx=%0d bps=%0d, want 2 / 6", ok, idx, o_tx_uart_bps);
        end
        i_req     = 4'b0000;
        i_cfg_bps = 3'd0;
        i_cfg_clk = 1'b0;
        bad  = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            tick();
            if (o_tx_uart_bps !== 3'd6 || o_tx_uart_clk !== 1'b1) bad = 1'b1;
            if (o_done === 4'b0100) seen = 1'b1;
        end
        n_cmp++;
        if (bad || !seen) begin
            n_bad++;
            $display("FAIL cfg_hold: changed=%0d done_seen=%0d, want 0 / 1", bad, seen);
        end
        i_req_data[31:24] = 8'h77;
        i_req             = 4'b1000;
        wait_evt(0, 20, idx, at, ok);
        n_cmp++;
        if (!ok || idx != 3 || o_tx_uart_bps !== 3'd0 || o_tx_uart_clk !== 1'b0 || o_tx_data !== 8'h77) begin
            n_bad++;
            $display("FAIL cfg_reload: idx=%0d bps=%0d clk=%b data=%h, want 3/0/0/77",
                     idx, o_tx_uart_bps, o_tx_uart_clk, o_tx_data);
        end
        i_req   = 4'b0000;
        rr_last = 3;
        wait_evt(1, 200, idx, at, ok);
        for (int n = 0; n < C_GAP + 2; n++) tick();
    endtask

    task automatic test_reset_mid();
        int idx, at, exp;
        bit ok;
        tx_auto     = 1'b0;
        i_tx_finish = 1'b0;
        i_req_data  = 32'hDEAD_BEEF;
        i_req       = 4'b0100;
        wait_evt(0, 20, idx, at, ok);
        i_req = 4'b0000;
        tick();
        tick();
        tick();
        n_cmp++;
        if (!ok || idx != 2 || o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_pre: ok=%0d idx=%0d busy=%b, want 2 / 1", ok, idx, o_busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o_busy !== 1'b0 || o_tx_flag !== 1'b0 || o_ack !== 4'b0 || o_done !== 4'b0 || o_err !== 1'b0 ||
            o_tx_data !== 8'h00 || o_grant_id !== 2'd0 || o_tx_uart_bps !== 3'd2 || o_tx_uart_clk !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_async: busy=%b flag=%b data=%h gid=%0d bps=%0d clk=%b, want 0/0/00/0/2/1",
                     o_busy, o_tx_flag, o_tx_data, o_grant_id, o_tx_uart_bps, o_tx_uart_clk);
        end
        tick();
        rst_n   = 1'b1;
        rr_last = C_NUM_REQ - 1;
        i_req   = 4'b1001;
        exp     = rr_pick(rr_last, i_req);
        wait_evt(0, 20, idx, at, ok);
        n_cmp++;
        if (!ok || idx != exp || idx != 0 || o_tx_data !== 8'hEF) begin
            n_bad++;
            $display("FAIL rstmid_regrant: idx=%0d data=%h, want 0 / EF", idx, o_tx_data);
        end
        rr_last = 0;
        i_req   = 4'b0000;
        tx_auto = 1'b1;
        wait_evt(1, 200, idx, at, ok);
        n_cmp++;
        if (!ok || idx != 0) begin
            n_bad++;
            $display("FAIL rstmid_done: ok=%0d idx=%0d, want 0", ok, idx);
        end
        for (int n = 0; n < C_GAP + 2; n++) tick();
    endtask

    task automatic test_enable();
        int idx, at, t0;
        bit ok, bad;
        i_en              = 1'b0;
        i_req_data[31:24] = 8'hC3;
        i_req             = 4'b1000;
        bad = 1'b0;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (o_ack !== 4'b0 || o_busy !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL en_block: grant seen while disabled, want none");
        end
        tx_auto     = 1'b0;
        i_tx_finish = 1'b1;
        tick();
        i_tx_finish = 1'b0;
        bad = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            if (o_done !== 4'b0 || o_err !== 1'b0 || o_busy !== 1'b0 || o_tx_flag !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL idle_finish: done=%b err=%b busy=%b, want 0000/0/0", o_done, o_err, o_busy);
        end
        tx_auto = 1'b1;
        i_en    = 1'b1;
        t0      = cyc;
        wait_evt(0, 10, idx, at, ok);
        n_cmp++;
        if (!ok || idx != 3 || at != t0 + 1 || o_tx_data !== 8'hC3) begin
            n_bad++;
            $display("FAIL en_ack: idx=%0d at=%0d data=%h, want 3 at=%0d data=C3", idx, at, o_tx_data, t0 + 1);
        end
        i_en              = 1'b0;
        i_req_data[31:24] = 8'h3D;
        wait_evt(1, 200, idx, at, ok);
        n_cmp++;
        if (!ok || idx != 3) begin
            n_bad++;
            $display("FAIL en_midframe_done: ok=%0d idx=%0d, want 3", ok, idx);
        end
        bad = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (o_ack !== 4'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad || o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL en_hold_idle: regrant=%0d busy=%b, want 0 / 0", bad, o_busy);
        end
        i_req = 4'b0000;
        i_en  = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        i_en        = 1'b1;
        i_req       = 4'b0000;
        i_req_data  = 32'h0;
        i_cfg_bps   = 3'd2;
        i_cfg_clk   = 1'b1;
        i_tx_finish = 1'b0;
        rr_last     = C_NUM_REQ - 1;

        test_reset();
        test_single();
        test_rr_all();
        test_random();
        test_timeout();
        test_cfg_hold();
        test_reset_mid();
        test_enable();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
